// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the iitk_mini_mips boot sequencer.
package mips_boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        RUN,
        DONE,
        TIMEOUT
    } boot_state_t;

    // Reset vector of the core; pc_in reads this while the core is held in reset.
    localparam logic [31:0] PC_BASE             = 32'h0040_0000;
    localparam int          DEFAULT_RESET_HOLD  = 2;
    localparam int          DEFAULT_RUN_TIMEOUT = 1024;

endpackage

// File: rtl/mips_boot_sequencer.sv
// Boot controller: streams a program into instruction memory, releases the core,
// then waits for the halt PC (or a run timeout) and captures the debug result.
module mips_boot_sequencer
    import mips_boot_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int RESET_HOLD  = DEFAULT_RESET_HOLD,
    parameter int RUN_TIMEOUT = DEFAULT_RUN_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    input  logic [31:0]       halt_pc,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              cpu_reset,
    output logic              init_mode,
    output logic              write_enable,
    output logic [ADDR_W-1:0] init_address,
    output logic [DATA_W-1:0] init_instruction,
    input  logic [31:0]       pc_in,
    input  logic [DATA_W-1:0] result_in,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [DATA_W-1:0] result,
    output logic [31:0]       cycles
);

    localparam int              HOLD_W   = (RESET_HOLD < 1) ? 1 : $clog2(RESET_HOLD + 1);
    localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LEN_ONE  = 1;
    localparam logic [31:0]     RUN_LAST = 32'(RUN_TIMEOUT - 1);

    boot_state_t       state_reg;
    logic [ADDR_W:0]   len_reg;
    logic [ADDR_W:0]   count_reg;
    logic [31:0]       halt_pc_reg;
    logic [HOLD_W-1:0] settle_reg;
    logic              cpu_reset_reg;
    logic              init_mode_reg;
    logic              write_enable_reg;
    logic [ADDR_W-1:0] init_address_reg;
    logic [DATA_W-1:0] init_instruction_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              timeout_reg;
    logic [DATA_W-1:0] result_reg;
    logic [31:0]       cycles_reg;

    assign s_ready          = (state_reg == LOAD) && (count_reg < len_reg);
    assign cpu_reset        = cpu_reset_reg;
    assign init_mode        = init_mode_reg;
    assign write_enable     = write_enable_reg;
    assign init_address     = init_address_reg;
    assign init_instruction = init_instruction_reg;
    assign busy             = busy_reg;
    assign done             = done_reg;
    assign timeout          = timeout_reg;
    assign result           = result_reg;
    assign cycles           = cycles_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg            <= IDLE;
            len_reg              <= '0;
            count_reg            <= '0;
            halt_pc_reg          <= '0;
            settle_reg           <= '0;
            cpu_reset_reg        <= 1'b1;
            init_mode_reg        <= 1'b1;
            write_enable_reg     <= 1'b0;
            init_address_reg     <= '0;
            init_instruction_reg <= '0;
            busy_reg             <= 1'b0;
            done_reg             <= 1'b0;
            timeout_reg          <= 1'b0;
            result_reg           <= '0;
            cycles_reg           <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE, TIMEOUT: begin
                    write_enable_reg <= 1'b0;
                    if (start) begin
                        // Clamp so a full-memory program never wraps the address.
                        len_reg       <= (prog_len > FULL_LEN) ? FULL_LEN : prog_len;
                        halt_pc_reg   <= halt_pc;
                        count_reg     <= '0;
                        settle_reg    <= '0;
                        cycles_reg    <= '0;
                        done_reg      <= 1'b0;
                        timeout_reg   <= 1'b0;
                        busy_reg      <= 1'b1;
                        cpu_reset_reg <= 1'b1;
                        init_mode_reg <= 1'b1;
                        state_reg     <= (prog_len == '0) ? SETTLE : LOAD;
                    end
                end
                LOAD: begin
                    if (s_valid && s_ready) begin
                        write_enable_reg     <= 1'b1;
                        init_address_reg     <= count_reg[ADDR_W-1:0];
                        init_instruction_reg <= s_data;
                        count_reg            <= count_reg + LEN_ONE;
                        if (count_reg + LEN_ONE == len_reg) begin
                            settle_reg <= '0;
                            state_reg  <= SETTLE;
                        end
                    end else begin
                        write_enable_reg <= 1'b0;
                    end
                end
                SETTLE: begin
                    // First SETTLE cycle may still carry the last write with init_mode=1.
                    write_enable_reg <= 1'b0;
                    init_mode_reg    <= 1'b0;
                    if (settle_reg == HOLD_W'(RESET_HOLD)) begin
                        cpu_reset_reg <= 1'b0;
                        state_reg     <= RUN;
                    end else begin
                        settle_reg <= settle_reg + 1'b1;
                    end
                end
                RUN: begin
                    if (pc_in == halt_pc_reg) begin
                        result_reg    <= result_in;
                        done_reg      <= 1'b1;
                        cpu_reset_reg <= 1'b1;
                        init_mode_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= DONE;
                    end else if (cycles_reg == RUN_LAST) begin
                        timeout_reg   <= 1'b1;
                        cpu_reset_reg <= 1'b1;
                        init_mode_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= TIMEOUT;
                    end else if (cycles_reg != '1) begin
                        cycles_reg <= cycles_reg + 32'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_boot_sequencer.sv
// Directed bench for mips_boot_sequencer with a tiny behavioural core model
// (PC counter plus a 4-word memory that yields imm0*imm1 once PC passes word 3).
module tb_mips_boot_sequencer;
    import mips_boot_pkg::*;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   prog_len = '0;
    logic [31:0]       halt_pc = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_data = '0;
    logic              cpu_reset;
    logic              init_mode;
    logic              write_enable;
    logic [ADDR_W-1:0] init_address;
    logic [DATA_W-1:0] init_instruction;
    logic [31:0]       pc_in;
    logic [DATA_W-1:0] result_in;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [DATA_W-1:0] result;
    logic [31:0]       cycles;

    mips_boot_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_HOLD(2), .RUN_TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .prog_len(prog_len), .halt_pc(halt_pc),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .cpu_reset(cpu_reset), .init_mode(init_mode), .write_enable(write_enable),
        .init_address(init_address), .init_instruction(init_instruction),
        .pc_in(pc_in), .result_in(result_in), .busy(busy), .done(done),
        .timeout(timeout), .result(result), .cycles(cycles)
    );

    always #5 clk = ~clk;

    // Core model
    logic [31:0] pc;
    logic [31:0] imem [4];
    always @(posedge clk) begin
        if (cpu_reset) pc <= PC_BASE;
        else           pc <= pc + 32'd4;
        if (write_enable && init_mode && init_address < 4) imem[init_address[1:0]] <= init_instruction;
    end
    assign pc_in     = pc;
    assign result_in = (pc >= PC_BASE + 32'd12) ? 32'(imem[0][15:0]) * 32'(imem[1][15:0]) : '0;

    logic [31:0] prog [3] = '{32'h2008_0006, 32'h2009_0007, 32'h0109_5018};

    int n_checks = 0;
    int n_errors = 0;
    int ready_cnt, hold_cnt, run_cnt, bad_we_cnt;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    always @(negedge clk) begin
        if (write_enable) begin
            wa_q.push_back(32'(init_address));
            wd_q.push_back(init_instruction);
            if (!init_mode) bad_we_cnt++;
            $display("write addr=%0d data=%08h", init_address, init_instruction);
        end
        if (s_ready) ready_cnt++;
        if (!init_mode && cpu_reset) hold_cnt++;
        if (!cpu_reset) run_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        ready_cnt = 0; hold_cnt = 0; run_cnt = 0; bad_we_cnt = 0;
        wa_q.delete(); wd_q.delete();
    endtask

    task automatic do_start(input logic [ADDR_W:0] l, input logic [31:0] h);
        @(posedge clk); #1;
        prog_len = l; halt_pc = h; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        int n = 0;
        s_valid = 1'b1; s_data = w;
        @(negedge clk);
        while (!s_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("stream_stall", 32'(s_ready), 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic send_prog(input int gap);
        for (int i = 0; i < 3; i++) begin
            send_word(prog[i]);
            if (i < 2) repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(done || timeout) && n < 200) begin @(negedge clk); n++; end
        check({tag, "_end"}, 32'(done | timeout), 1);
        @(negedge clk);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, 32'(wa_q.size()), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < wa_q.size()) begin
                check($sformatf("%s_addr%0d", tag, i), wa_q[i], 32'(i));
                check($sformatf("%s_data%0d", tag, i), wd_q[i], prog[i]);
            end
        end
        check({tag, "_we_init"}, 32'(bad_we_cnt), 0);
    endtask

    initial begin
        clear_mon();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_reset", 32'(cpu_reset), 1);
        check("rst_init_mode", 32'(init_mode), 1);
        check("rst_we", 32'(write_enable), 0);
        check("rst_addr", 32'(init_address), 0);
        check("rst_instr", init_instruction, 0);
        check("rst_ready", 32'(s_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_flags", {30'd0, done, timeout}, 0);
        check("rst_result", result, 0);
        check("rst_cycles", cycles, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Multiply program
        clear_mon();
        do_start(3, 32'h0040_000C);
        check("mul_busy", 32'(busy), 1);
        send_prog(0);
        wait_end("mul");
        $display("test multiply: done=%0d result=%0d", done, result);
        check_writes("mul");
        check("mul_done", 32'(done), 1);
        check("mul_result", result, 42);
        check("mul_timeout", 32'(timeout), 0);
        check("mul_hold", 32'(hold_cnt), 2);
        check("mul_cpu_reset", 32'(cpu_reset), 1);
        check("mul_busy_end", 32'(busy), 0);

        // Backpressure: s_valid low 3 cycles between words
        clear_mon();
        do_start(3, 32'h0040_000C);
        send_prog(3);
        wait_end("bp");
        $display("test backpressure: done=%0d result=%0d", done, result);
        check_writes("bp");
        check("bp_result", result, 42);
        check("bp_done", 32'(done), 1);

        // Timeout: halt PC never reached
        clear_mon();
        do_start(3, 32'hFFFF_FFF0);
        send_prog(0);
        wait_end("to");
        $display("test timeout: timeout=%0d cycles=%0d", timeout, cycles);
        check("to_timeout", 32'(timeout), 1);
        check("to_cycles", cycles, 15);
        check("to_done", 32'(done), 0);
        check("to_cpu_reset", 32'(cpu_reset), 1);
        check("to_init_mode", 32'(init_mode), 1);
        check("to_result", result, 42);
        check("to_run_cycles", 32'(run_cnt), 16);

        // Empty program: halt at the reset vector
        clear_mon();
        do_start(0, PC_BASE);
        wait_end("empty");
        $display("test empty: done=%0d result=%0d", done, result);
        check("empty_nwr", 32'(wa_q.size()), 0);
        check("empty_ready", 32'(ready_cnt), 0);
        check("empty_hold", 32'(hold_cnt), 2);
        check("empty_done", 32'(done), 1);
        check("empty_result", result, 0);
        check("empty_cycles", cycles, 0);

        // Reset mid-load, then reload
        clear_mon();
        do_start(3, 32'h0040_000C);
        send_word(prog[0]);
        send_word(prog[1]);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        $display("test reset mid-load: writes=%0d", wa_q.size());
        check("mid_cpu_reset", 32'(cpu_reset), 1);
        check("mid_init_mode", 32'(init_mode), 1);
        check("mid_we", 32'(write_enable), 0);
        check("mid_busy", 32'(busy), 0);
        check("mid_ready", 32'(s_ready), 0);
        check("mid_result", result, 0);
        clear_mon();
        do_start(3, 32'h0040_000C);
        send_prog(0);
        wait_end("reload");
        check_writes("reload");
        check("reload_result", result, 42);

        // Start pulsed during RUN is ignored
        clear_mon();
        do_start(3, 32'h0040_000C);
        send_prog(0);
        begin
            int n = 0;
            while (cpu_reset && n < 50) begin @(negedge clk); n++; end
            check("busy_run_reached", 32'(cpu_reset), 0);
        end
        @(posedge clk); #1;
        prog_len = 0; halt_pc = 32'hFFFF_FFF0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_end("busy");
        $display("test start-while-busy: done=%0d result=%0d", done, result);
        check("busy_done", 32'(done), 1);
        check("busy_timeout", 32'(timeout), 0);
        check("busy_result", result, 42);
        check("busy_nwr", 32'(wa_q.size()), 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_boot_sequencer.md
Name: mips_boot_sequencer

Overview:
- Sequences bring-up of the iitk_mini_mips core.
- Accepts a program as a valid/ready instruction stream and writes it into instruction memory through the core's init port (init_mode / write_enable / init_address / init_instruction).
- Then releases core reset, watches pc_out for a halt address, and captures the core's debug_result.
- Replaces hand-timed testbench loading and is the boot controller for FPGA bring-up.

Parameters:
- ADDR_W, 12: instruction-memory word-address width.
- DATA_W, 32: instruction and result width.
- RESET_HOLD, 2: cycles core reset stays asserted after load, with init_mode=0, before release.
- RUN_TIMEOUT, 1024: maximum RUN cycles before abort.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a load+run sequence.
- prog_len  in  ADDR_W+1  instruction count; sampled on accepted start.
- halt_pc  in  32  PC value that terminates RUN; sampled on accepted start.
- s_valid  in  1  instruction stream valid.
- s_ready  out  1  instruction stream ready.
- s_data  in  DATA_W  instruction word.
- cpu_reset  out  1  reset to the core.
- init_mode  out  1  core init-mode select.
- write_enable  out  1  instruction-memory write strobe.
- init_address  out  ADDR_W  instruction-memory write address.
- init_instruction  out  DATA_W  instruction-memory write data.
- pc_in  in  32  core pc_out.
- result_in  in  DATA_W  core debug_result.
- busy  out  1  high in LOAD/SETTLE/RUN.
- done  out  1  level; halt reached.
- timeout  out  1  level; RUN_TIMEOUT expired.
- result  out  DATA_W  captured result_in.
- cycles  out  32  RUN cycle count.

Behaviour:
- Reset values:
  - cpu_reset=1, init_mode=1.
  - write_enable=0, init_address=0, init_instruction=0.
  - s_ready=0, busy=0, done=0, timeout=0, result=0, cycles=0.
  - state=IDLE.
- All outputs are registered except s_ready, which is combinational: (state==LOAD) && (count < len).
- State IDLE/DONE/TIMEOUT:
  - On start: latch len=min(prog_len, 2^ADDR_W) and halt_pc; clear done, timeout, cycles and count.
  - Next state is LOAD, or SETTLE if len==0.
  - start is ignored in LOAD/SETTLE/RUN.
- State LOAD: cpu_reset=1, init_mode=1.
  - On s_valid&&s_ready: next edge drives write_enable=1, init_address=count, init_instruction=s_data, then count++. This gives a one-cycle write latency.
  - With no handshake in a cycle, write_enable=0 the next cycle.
  - Gaps in s_valid are legal; addresses stay contiguous.
  - After the handshake where count becomes len, go to SETTLE; the final write_enable pulse still issues.
- State SETTLE:
  - write_enable=0, init_mode=0, cpu_reset=1 for exactly RESET_HOLD cycles.
  - Then cpu_reset=0 and go to RUN.
- State RUN: cycles++ every clock.
  - If pc_in==halt_pc: result<=result_in, done=1, cpu_reset=1, init_mode=1, go to DONE.
  - Else if cycles==RUN_TIMEOUT-1: timeout=1, cpu_reset=1, init_mode=1, go to TIMEOUT; result keeps its old value.
  - If halt and timeout occur in the same cycle, halt wins.
- Counter widths:
  - cycles saturates at 2^32-1, never wraps.
  - count is ADDR_W+1 bits, so a full 2^ADDR_W program does not wrap the address.
- Reset asserted in any state: all outputs return to reset values on the same edge. A partially loaded memory is not cleared.
- done/timeout hold until the next accepted start.

Decomposition:
- Shared package mips_boot_pkg holds:
  - state enum (IDLE, LOAD, SETTLE, RUN, DONE, TIMEOUT);
  - PC_BASE = 32'h0040_0000;
  - default RESET_HOLD and RUN_TIMEOUT constants.
- No sub-module; a single FSM with counters.

Test Plan:
- Multiply program:
  - Stimulus: stream 0x20080006, 0x20090007, 0x01095018 with prog_len=3, halt_pc=0x0040000C.
  - Required: writes at addresses 0,1,2; cpu_reset falls RESET_HOLD cycles after LOAD exits; done=1, result=42, timeout=0.
- Backpressure:
  - Stimulus: same program with s_valid low for 3 cycles between words.
  - Required: exactly 3 write_enable pulses, addresses 0,1,2, identical result 42.
- Timeout:
  - Stimulus: RUN_TIMEOUT=16, halt_pc=0xFFFFFFF0.
  - Required: timeout=1 after 16 RUN cycles, cycles=15, done=0, cpu_reset=1, result unchanged.
- Empty program:
  - Stimulus: prog_len=0.
  - Required: no write_enable pulse, s_ready never high, SETTLE then RUN entered directly.
- Reset mid-load:
  - Stimulus: assert reset after 2 of 3 words.
  - Required: next edge cpu_reset=1, init_mode=1, write_enable=0, busy=0, state IDLE; a fresh start reloads from address 0.
- Start while busy:
  - Stimulus: pulse start during RUN.
  - Required: ignored; the sequence completes with the original halt_pc and done=1.
